counter_req_shaper: RTL and testbench



---
 rtl/counter_pkg.sv | 12 +
 rtl/counter_req_slot.sv | 44 ++++
 rtl/counter_req_shaper.sv | 175 +++++++++++++++++
 tb/tb_counter_req_shaper.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared widths and arithmetic types for the counter request shaper.
package counter_pkg;

    localparam int unsigned WIDTH  = 4;
    localparam int unsigned STEP_W = 2;
    localparam int unsigned MAX    = 2**WIDTH - 1;

    typedef logic [WIDTH-1:0]         cnt_t;
    typedef logic [STEP_W-1:0]        step_t;
    typedef logic signed [WIDTH+1:0]  calc_t;

endpackage

// File: rtl/counter_req_slot.sv
// One-entry request holding register with valid/ready; the entry clears when issued,
// and a new request may be captured in the same edge that the old one issues.
module counter_req_slot #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         ready_o,
    input  logic         issue_i,
    output logic         pend_o,
    output logic [W-1:0] data_o
);

    logic         pend_q, pend_d;
    logic [W-1:0] data_q, data_d;

    assign ready_o = !pend_q || issue_i;
    assign pend_o  = pend_q;
    assign data_o  = data_q;

    always_comb begin
        pend_d = pend_q;
        data_d = data_q;
        if (valid_i && ready_o) begin
            pend_d = 1'b1;
            data_d = data_i;
        end else if (issue_i) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 1'b0;
            data_q <= '0;
        end else begin
            pend_q <= pend_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/counter_req_shaper.sv
// Range-checked feeder for the up/down counter: inc/dec/init requests are held and issued
// only when the counter cannot wrap. COUNTER_REQ_SHAPER_STALL_CNT_EN adds stall_count.
module counter_req_shaper #(
    parameter int unsigned WIDTH  = counter_pkg::WIDTH,
    parameter int unsigned STEP_W = counter_pkg::STEP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc_req_valid,
    input  logic [STEP_W-1:0] inc_req_amt,
    output logic              inc_req_ready,
    input  logic              dec_req_valid,
    input  logic [STEP_W-1:0] dec_req_amt,
    output logic              dec_req_ready,
    input  logic              init_req_valid,
    input  logic [WIDTH-1:0]  init_req_value,
    output logic              init_req_ready,
    input  logic [WIDTH-1:0]  cnt_value,
    output logic              incr_valid,
    output logic [STEP_W-1:0] incr,
    output logic              decr_valid,
    output logic [STEP_W-1:0] decr,
    output logic              reinit,
    output logic [WIDTH-1:0]  initial_value
`ifdef COUNTER_REQ_SHAPER_STALL_CNT_EN
    ,
    output logic [7:0]        stall_count
`endif
);

    localparam int unsigned CW = WIDTH + 2;
    localparam logic signed [CW-1:0] MaxS = CW'(2**WIDTH - 1);

    logic              pend_inc, pend_dec, pend_init;
    logic [STEP_W-1:0] inc_amt, dec_amt;
    logic [WIDTH-1:0]  init_val;
    logic              issue_inc, issue_dec, issue_init;

    logic              incr_valid_q, incr_valid_d;
    logic [STEP_W-1:0] incr_q, incr_d;
    logic              decr_valid_q, decr_valid_d;
    logic [STEP_W-1:0] decr_q, decr_d;
    logic              reinit_q, reinit_d;
    logic [WIDTH-1:0]  init_value_q, init_value_d;

    logic signed [CW-1:0] base, a_ext, b_ext, net_inc, net_dec, net_both;

    counter_req_slot #(.W(STEP_W)) u_inc_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (inc_req_valid),
        .data_i  (inc_req_amt),
        .ready_o (inc_req_ready),
        .issue_i (issue_inc),
        .pend_o  (pend_inc),
        .data_o  (inc_amt)
    );

    counter_req_slot #(.W(STEP_W)) u_dec_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (dec_req_valid),
        .data_i  (dec_req_amt),
        .ready_o (dec_req_ready),
        .issue_i (issue_dec),
        .pend_o  (pend_dec),
        .data_o  (dec_amt)
    );

    counter_req_slot #(.W(WIDTH)) u_init_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (init_req_valid),
        .data_i  (init_req_value),
        .ready_o (init_req_ready),
        .issue_i (issue_init),
        .pend_o  (pend_init),
        .data_o  (init_val)
    );

    assign a_ext = $signed({{(CW-STEP_W){1'b0}}, inc_amt});
    assign b_ext = $signed({{(CW-STEP_W){1'b0}}, dec_amt});

    // Base is the value the counter holds after consuming the command driven right now;
    // incr_q/decr_q are already zero whenever their valid is low.
    always_comb begin
        if (reinit_q) begin
            base = $signed({2'b00, init_value_q});
        end else begin
            base = $signed({2'b00, cnt_value})
                 + $signed({{(CW-STEP_W){1'b0}}, incr_q})
                 - $signed({{(CW-STEP_W){1'b0}}, decr_q});
        end
    end

    assign net_inc  = base + a_ext;
    assign net_dec  = base - b_ext;
    assign net_both = net_inc - b_ext;

    always_comb begin
        issue_init = pend_init;
        issue_inc  = 1'b0;
        issue_dec  = 1'b0;
        if (!pend_init) begin
            if (pend_inc && pend_dec && !net_both[CW-1] && (net_both <= MaxS)) begin
                issue_inc = 1'b1;
                issue_dec = 1'b1;
            end else if (pend_inc && (net_inc <= MaxS)) begin
                issue_inc = 1'b1;
            end else if (pend_dec && !net_dec[CW-1]) begin
                issue_dec = 1'b1;
            end
        end
    end

    always_comb begin
        incr_valid_d = issue_inc;
        incr_d       = issue_inc ? inc_amt : '0;
        decr_valid_d = issue_dec;
        decr_d       = issue_dec ? dec_amt : '0;
        reinit_d     = issue_init;
        init_value_d = issue_init ? init_val : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            incr_valid_q <= 1'b0;
            incr_q       <= '0;
            decr_valid_q <= 1'b0;
            decr_q       <= '0;
            reinit_q     <= 1'b0;
            init_value_q <= '0;
        end else begin
            incr_valid_q <= incr_valid_d;
            incr_q       <= incr_d;
            decr_valid_q <= decr_valid_d;
            decr_q       <= decr_d;
            reinit_q     <= reinit_d;
            init_value_q <= init_value_d;
        end
    end

    assign incr_valid    = incr_valid_q;
    assign incr          = incr_q;
    assign decr_valid    = decr_valid_q;
    assign decr          = decr_q;
    assign reinit        = reinit_q;
    assign initial_value = init_value_q;

`ifdef COUNTER_REQ_SHAPER_STALL_CNT_EN
    logic       stall;
    logic [7:0] stall_q, stall_d;

    // Only range-check holds count; waiting behind an init does not.
    assign stall = !pend_init && ((pend_inc && !issue_inc) || (pend_dec && !issue_dec));

    always_comb begin
        stall_d = stall_q;
        if (stall && (stall_q != 8'hff)) begin
            stall_d = stall_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 8'd0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_counter_req_shaper.sv
// Self-checking bench: a behavioural counter plus an integer model of the shaper's rules.
module tb_counter_req_shaper;
    import counter_pkg::*;

    logic  clk = 1'b0;
    logic  rst_n;
    logic  inc_req_valid, dec_req_valid, init_req_valid;
    step_t inc_req_amt, dec_req_amt;
    cnt_t  init_req_value;
    logic  inc_req_ready, dec_req_ready, init_req_ready;
    cnt_t  cnt_value;
    logic  incr_valid, decr_valid, reinit;
    step_t incr, decr;
    cnt_t  initial_value;
`ifdef COUNTER_REQ_SHAPER_STALL_CNT_EN
    logic [7:0] stall_count;
`endif

    always #5 clk = ~clk;

    counter_req_shaper dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .inc_req_valid  (inc_req_valid),
        .inc_req_amt    (inc_req_amt),
        .inc_req_ready  (inc_req_ready),
        .dec_req_valid  (dec_req_valid),
        .dec_req_amt    (dec_req_amt),
        .dec_req_ready  (dec_req_ready),
        .init_req_valid (init_req_valid),
        .init_req_value (init_req_value),
        .init_req_ready (init_req_ready),
        .cnt_value      (cnt_value),
        .incr_valid     (incr_valid),
        .incr           (incr),
        .decr_valid     (decr_valid),
        .decr           (decr),
        .reinit         (reinit),
        .initial_value  (initial_value)
`ifdef COUNTER_REQ_SHAPER_STALL_CNT_EN
        ,
        .stall_count    (stall_count)
`endif
    );

    int checks = 0;
    int failures = 0;

    // Model state: pending requests and the command currently presented to the counter.
    bit m_pi, m_pd, m_pn;
    int m_ai, m_ad, m_an;
    bit m_iv, m_dv, m_rv;
    int m_i, m_d, m_rval;
    int m_stall;
    int m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pi = 0; m_pd = 0; m_pn = 0;
        m_ai = 0; m_ad = 0; m_an = 0;
        m_iv = 0; m_dv = 0; m_rv = 0;
        m_i = 0; m_d = 0; m_rval = 0;
        m_stall = 0;
    endtask

    task automatic drive(input bit iv, input int ia, input bit dv, input int da,
                         input bit nv, input int nval);
        inc_req_valid  = iv;
        inc_req_amt    = step_t'(ia);
        dec_req_valid  = dv;
        dec_req_amt    = step_t'(da);
        init_req_valid = nv;
        init_req_value = cnt_t'(nval);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_incr_valid"}, incr_valid, 0);
        chk({tag, "_incr"}, incr, 0);
        chk({tag, "_decr_valid"}, decr_valid, 0);
        chk({tag, "_decr"}, decr, 0);
        chk({tag, "_reinit"}, reinit, 0);
        chk({tag, "_initial_value"}, initial_value, 0);
        chk({tag, "_inc_ready"}, inc_req_ready, 1);
        chk({tag, "_dec_ready"}, dec_req_ready, 1);
        chk({tag, "_init_ready"}, init_req_ready, 1);
`ifdef COUNTER_REQ_SHAPER_STALL_CNT_EN
        chk({tag, "_stall_count"}, stall_count, 0);
`endif
    endtask

    // One clock of stimulus: inputs are held from posedge+1 through the next edge.
    task automatic step();
        int base, nc;
        bit ii, id, in, stall, acc_i, acc_d, acc_n;
        bit o_iv, o_dv, o_rv;
        int o_i, o_d, o_rval;
        #1;
        o_iv = incr_valid; o_i = int'(incr);
        o_dv = decr_valid; o_d = int'(decr);
        o_rv = reinit;     o_rval = int'(initial_value);
        base = m_rv ? m_rval : m_cnt + (m_iv ? m_i : 0) - (m_dv ? m_d : 0);
        in = m_pn; ii = 0; id = 0;
        if (!m_pn) begin
            if (m_pi && m_pd && (base + m_ai - m_ad >= 0) && (base + m_ai - m_ad <= MAX)) begin
                ii = 1; id = 1;
            end else if (m_pi && (base + m_ai <= MAX)) begin
                ii = 1;
            end else if (m_pd && (base - m_ad >= 0)) begin
                id = 1;
            end
        end
        stall = !m_pn && ((m_pi && !ii) || (m_pd && !id));
        chk("inc_req_ready", inc_req_ready, !m_pi || ii);
        chk("dec_req_ready", dec_req_ready, !m_pd || id);
        chk("init_req_ready", init_req_ready, !m_pn || in);
        acc_i = inc_req_valid && (!m_pi || ii);
        acc_d = dec_req_valid && (!m_pd || id);
        acc_n = init_req_valid && (!m_pn || in);
        @(posedge clk);
        #1;
        // The counter consumes whatever the DUT actually drove before this edge.
        nc = o_rv ? o_rval : m_cnt + (o_iv ? o_i : 0) - (o_dv ? o_d : 0);
        checks++;
        if (nc < 0 || nc > MAX) begin
            failures++;
            $display("FAIL counter_range: got %0d expected 0..%0d", nc, MAX);
            nc = (nc < 0) ? 0 : MAX;
        end
        m_cnt = nc;
        cnt_value = cnt_t'(nc);
        m_iv = ii; m_i = ii ? m_ai : 0;
        m_dv = id; m_d = id ? m_ad : 0;
        m_rv = in; m_rval = in ? m_an : 0;
        if (acc_i) begin m_pi = 1; m_ai = int'(inc_req_amt); end else if (ii) m_pi = 0;
        if (acc_d) begin m_pd = 1; m_ad = int'(dec_req_amt); end else if (id) m_pd = 0;
        if (acc_n) begin m_pn = 1; m_an = int'(init_req_value); end else if (in) m_pn = 0;
        if (stall && m_stall < 255) m_stall++;
        chk("incr_valid", incr_valid, m_iv);
        chk("incr", incr, m_i);
        chk("decr_valid", decr_valid, m_dv);
        chk("decr", decr, m_d);
        chk("reinit", reinit, m_rv);
        chk("initial_value", initial_value, m_rval);
`ifdef COUNTER_REQ_SHAPER_STALL_CNT_EN
        chk("stall_count", stall_count, m_stall);
`endif
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic set_cnt(input int v);
        m_cnt = v;
        cnt_value = cnt_t'(v);
    endtask

    // Called at posedge+1: asserts reset mid-cycle, checks the asynchronous clear.
    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_cleared(tag);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int pulses;

    initial begin
        rst_n = 1'b0;
        drive(1, 1, 1, 1, 1, 5);
        set_cnt(0);
        model_reset();
        #2;
        chk_cleared("reset");
        @(posedge clk);
        #1;
        chk_cleared("reset_edge");
        rst_n = 1'b1;
        step();
        idle(4);

        // Inc 3 at 14 stalls until dec 2 makes the net 15.
        set_cnt(14);
        drive(1, 3, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk("s1_hold_incr_valid", incr_valid, 0);
        chk("s1_hold_inc_ready", inc_req_ready, 0);
        drive(0, 0, 1, 2, 0, 0);
        step();
        chk("s1_dec_accept_incr_valid", incr_valid, 0);
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk("s1_both_incr_valid", incr_valid, 1);
        chk("s1_both_incr", incr, 3);
        chk("s1_both_decr_valid", decr_valid, 1);
        chk("s1_both_decr", decr, 2);
        idle(3);
        chk("s1_cnt", cnt_value, 15);

        // Dec 1 at zero holds until inc 2 arrives.
        set_cnt(0);
        drive(0, 0, 1, 1, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("s2_dec_ready", dec_req_ready, 0);
            chk("s2_decr_valid", decr_valid, 0);
        end
        drive(1, 2, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk("s2_incr", incr, 2);
        chk("s2_decr", decr, 1);
        chk("s2_decr_valid", decr_valid, 1);
        idle(3);
        chk("s2_cnt", cnt_value, 1);

        // Init takes priority; the pending inc then uses the new base.
        drive(1, 1, 0, 0, 1, 9);
        step();
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk("s3_reinit", reinit, 1);
        chk("s3_initial_value", initial_value, 9);
        chk("s3_incr_valid_n", incr_valid, 0);
        step();
        chk("s3_incr_valid_n1", incr_valid, 1);
        chk("s3_incr_n1", incr, 1);
        chk("s3_reinit_n1", reinit, 0);
        idle(3);
        chk("s3_cnt", cnt_value, 10);

        // Back-to-back inc 1 from 12: three issues via in-flight accounting, then stall.
        set_cnt(12);
        drive(1, 1, 0, 0, 0, 0);
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (incr_valid) pulses++;
        end
        chk("s4_pulses", pulses, 3);
        chk("s4_inc_ready", inc_req_ready, 0);
        chk("s4_cnt", cnt_value, 15);
        drive(0, 0, 0, 0, 0, 0);
        apply_reset("s4_reset");

        // Reset while an inc is driven and a dec is still held.
        set_cnt(1);
        drive(1, 1, 1, 3, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk("s5_incr_valid", incr_valid, 1);
        chk("s5_dec_ready", dec_req_ready, 0);
        apply_reset("s5_reset");
        chk("s5_dec_ready_after", dec_req_ready, 1);
        step();
        chk("s5_decr_valid_after", decr_valid, 0);
        chk("s5_cnt", cnt_value, 1);

        // Randomized traffic checked by the model every cycle.
        for (int k = 0; k < 3000; k++) begin
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 3),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 3),
                  $urandom_range(0, 9) == 0, $urandom_range(0, MAX));
            if ($urandom_range(0, 299) == 0) apply_reset("rand_reset");
            else step();
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
